// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package div_pkg;

    localparam int unsigned DIV_DW = 16;
    localparam int unsigned DIV_VW = 8;
    localparam int unsigned DIV_CW = $clog2(DIV_DW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring step: shift in a dividend bit, trial-subtract the divisor.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned VW = DIV_VW
) (
    input  logic [VW-1:0] prem_i,
    input  logic          bit_i,
    input  logic [VW-1:0] divisor_i,
    output logic [VW-1:0] prem_o,
    output logic          q_bit_o
);

    logic [VW:0] trial;

    // The partial remainder stays below the divisor, so the difference always fits in VW bits.
    always_comb begin
        trial   = {prem_i, bit_i};
        q_bit_o = (trial >= {1'b0, divisor_i});
        prem_o  = q_bit_o ? (trial[VW-1:0] - divisor_i) : trial[VW-1:0];
    end

endmodule

// File: rtl/div_16x8_seq.sv
// Sequential DW/VW unsigned restoring divider with valid/ready on both sides, one op in flight.
module div_16x8_seq
    import div_pkg::*;
#(
    parameter int unsigned DW = DIV_DW,
    parameter int unsigned VW = DIV_VW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_zero
);

    localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

    div_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] work_q, work_d;
    logic [VW-1:0] prem_q, prem_d;
    logic [VW-1:0] dvs_q, dvs_d;
    logic [DW-1:0] quot_q, quot_d;
    logic [VW-1:0] rem_q, rem_d;
    logic          dz_q, dz_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;

    logic          accept;
    logic          step_qbit;
    logic [VW-1:0] step_prem;
    logic [DW-1:0] work_shl;

    div_step #(
        .VW (VW)
    ) u_step (
        .prem_i    (prem_q),
        .bit_i     (work_q[DW-1]),
        .divisor_i (dvs_q),
        .prem_o    (step_prem),
        .q_bit_o   (step_qbit)
    );

    // work_q starts as the dividend and fills with quotient bits from the LSB as the MSBs are consumed.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        prem_d      = prem_q;
        dvs_d       = dvs_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        dz_d        = dz_q;
        out_valid_d = out_valid_q;

        accept   = in_valid && in_ready_q;
        work_shl = (work_q << 1) | DW'(step_qbit);

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    dvs_d = divisor;
                    if (divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = dividend[VW-1:0];
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        work_d  = dividend;
                        prem_d  = '0;
                        cnt_d   = CW'(DW - 1);
                        dz_d    = 1'b0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                work_d = work_shl;
                prem_d = step_prem;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    quot_d      = work_shl;
                    rem_d       = step_prem;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                // A divide-by-zero lands here with out_valid low and raises it one cycle later.
                out_valid_d = 1'b1;
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase

        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            prem_q      <= '0;
            dvs_q       <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            dz_q        <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            prem_q      <= prem_d;
            dvs_q       <= dvs_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            dz_q        <= dz_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_div_16x8_seq.sv
// Scoreboard bench for div_16x8_seq: directed timing/backpressure/reset cases plus random traffic.
module tb_div_16x8_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_zero;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] q;
        logic [7:0]  r;
        logic        z;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   rand_done = 1'b0;

    div_16x8_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == 8'd0) begin
            e.q = 16'hFFFF;
            e.r = a[7:0];
            e.z = 1'b1;
        end else begin
            e.q = a / {8'd0, b};
            e.r = 8'(a % {8'd0, b});
            e.z = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Result monitor: out_valid && out_ready seen at a falling edge means a handshake at the next rising edge.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_result: got q=0x%0h r=0x%0h z=%0b, expected no result", quotient, remainder, div_zero);
            end else begin
                e = sb.pop_front();
                chk($sformatf("quotient %0h/%0h", e.a, e.b), 32'(quotient), 32'(e.q));
                chk($sformatf("remainder %0h/%0h", e.a, e.b), 32'(remainder), 32'(e.r));
                chk($sformatf("div_zero %0h/%0h", e.a, e.b), 32'(div_zero), 32'(e.z));
                if (!e.z) begin
                    chk("identity", 32'(quotient) * 32'(e.b) + 32'(remainder), 32'(e.a));
                    chk("rem_lt_div", 32'(remainder < e.b), 32'd1);
                end
            end
        end
    end

    // Present operands; while the DUT is busy, toggle in_valid and scramble operands to show they are ignored.
    task automatic send(input logic [15:0] a, input logic [7:0] b, input bit push, input exp_t e);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            in_valid = 1'($urandom);
            dividend = 16'($urandom);
            divisor  = 8'($urandom);
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_checks++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", guard);
            in_valid = 1'b0;
            return;
        end
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        if (push) sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!out_valid) begin
            n_checks++;
            $display("FAIL %s: out_valid stayed 0 for %0d cycles, expected 1", name, k);
        end
    endtask

    task automatic measure(input string name, input int exp_lat);
        int k;
        k = 0;
        do begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end while (!out_valid && k < 40);
        chk(name, 32'(k), 32'(exp_lat));
    endtask

    task automatic wait_drain(input int max);
        int k;
        k = 0;
        while (sb.size() != 0 && k < max) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        exp_t        e;
        exp_t        dummy;
        logic [15:0] a16;
        int          ra;
        int          rb;

        dummy     = model(16'd0, 8'd1);
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #1 rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        chk("rst_div_zero", 32'(div_zero), 32'd0);
        rst_n = 1'b1;
        #1 chk("release_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 chk("release_in_ready_high", 32'(in_ready), 32'd1);

        // Directed results with latency measurement
        out_ready = 1'b1;
        send(16'hC350, 8'hC8, 1'b1, model(16'hC350, 8'hC8));
        measure("latency_nonzero", 16);
        wait_drain(40);
        chk("basic_expected_q", 32'(model(16'hC350, 8'hC8).q), 32'h00FA);
        send(16'h03E8, 8'h07, 1'b1, model(16'h03E8, 8'h07));
        wait_drain(40);
        send(16'hFFFF, 8'h01, 1'b1, model(16'hFFFF, 8'h01));
        wait_drain(40);
        send(16'h0005, 8'hFF, 1'b1, model(16'h0005, 8'hFF));
        wait_drain(40);
        send(16'h1234, 8'h00, 1'b1, model(16'h1234, 8'h00));
        measure("latency_zero", 1);
        wait_drain(40);

        // Backpressure: result held for 5 cycles with a competing request present
        out_ready = 1'b0;
        e = model(16'h03E8, 8'h07);
        send(16'h03E8, 8'h07, 1'b1, e);
        wait_valid("bp_wait_valid");
        in_valid = 1'b1;
        dividend = 16'h1111;
        divisor  = 8'h22;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_quotient_held", 32'(quotient), 32'h008E);
            chk("bp_remainder_held", 32'(remainder), 32'h06);
            chk("bp_out_valid_held", 32'(out_valid), 32'd1);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hs_in_ready_next", 32'(in_ready), 32'd1);
        chk("hs_out_valid_drop", 32'(out_valid), 32'd0);
        wait_drain(10);

        // Reset during CALC: operation discarded
        send(16'hC350, 8'hC8, 1'b0, dummy);
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("calc_rst_out_valid", 32'(out_valid), 32'd0);
        chk("calc_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("calc_rel_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 chk("calc_rel_in_ready_high", 32'(in_ready), 32'd1);
        send(16'h03E8, 8'h07, 1'b1, model(16'h03E8, 8'h07));
        wait_drain(40);

        // Reset while a result waits in DONE: out_valid drops asynchronously
        out_ready = 1'b0;
        send(16'h1234, 8'h00, 1'b0, dummy);
        wait_valid("done_wait_valid");
        #2 rst_n = 1'b0;
        #1;
        chk("done_rst_out_valid", 32'(out_valid), 32'd0);
        chk("done_rst_in_ready", 32'(in_ready), 32'd0);
        chk("done_rst_div_zero", 32'(div_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("done_rel_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;

        // Round trip: exact products must divide back to the original operand
        for (int i = 0; i < 404; i++) begin
            if (i < 4) begin
                ra = (i[0]) ? 255 : 1;
                rb = (i[1]) ? 255 : 1;
            end else begin
                ra = int'($urandom_range(1, 255));
                rb = int'($urandom_range(1, 255));
            end
            a16 = 16'(ra * rb);
            e.a = a16;
            e.b = 8'(rb);
            e.q = 16'(ra);
            e.r = 8'd0;
            e.z = 1'b0;
            send(a16, 8'(rb), 1'b1, e);
        end
        wait_drain(60);

        // Random traffic with random consumer backpressure
        fork
            begin
                logic [15:0] ta;
                logic [7:0]  tb;
                for (int i = 0; i < 300; i++) begin
                    ta = 16'($urandom);
                    tb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
                    send(ta, tb, 1'b1, model(ta, tb));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_drain(200);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
